// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU command codes and NZCV bit positions.
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_alu_stage_alu_core.sv
// Combinational ALU: result plus next NZCV; C/V pass through for non-arithmetic commands.
module alu_core
  import exe_pkg::*;
(
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [3:0]  cmd,
  input  logic        c_in,
  input  logic        v_in,
  output logic [31:0] result,
  output logic [3:0]  nzcv_next
);

  logic [32:0] w_sum;
  logic        w_c;
  logic        w_v;

  always_comb begin
    w_sum  = '0;
    result = '0;
    w_c    = c_in;
    w_v    = v_in;
    case (cmd)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD, CMD_ADC: begin
        w_sum  = {1'b0, val1} + {1'b0, val2} + {32'b0, (cmd == CMD_ADC) & c_in};
        result = w_sum[31:0];
        w_c    = w_sum[32];
        w_v    = (val1[31] == val2[31]) & (w_sum[31] != val1[31]);
      end
      // Subtraction as a + ~b + carry so bit 32 is directly the NOT-borrow carry.
      CMD_SUB, CMD_SBC: begin
        w_sum  = {1'b0, val1} + {1'b0, ~val2} + {32'b0, (cmd == CMD_SUB) | c_in};
        result = w_sum[31:0];
        w_c    = w_sum[32];
        w_v    = (val1[31] != val2[31]) & (w_sum[31] != val1[31]);
      end
      CMD_AND: result = val1 & val2;
      CMD_ORR: result = val1 | val2;
      CMD_EOR: result = val1 ^ val2;
      default: result = '0;
    endcase
    nzcv_next         = '0;
    nzcv_next[FLAG_N] = result[31];
    nzcv_next[FLAG_Z] = (result == 32'd0);
    nzcv_next[FLAG_C] = w_c;
    nzcv_next[FLAG_V] = w_v;
  end

endmodule

// File: rtl/exe_alu_stage.sv
// Execute stage: ALU, architectural NZCV register and the EXE/MEM pipeline register.
module exe_alu_stage
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [3:0]       exe_cmd,
  input  logic             s_bit,
  input  logic             wb_en_in,
  input  logic             mem_r_in,
  input  logic             mem_w_in,
  input  logic [3:0]       dest_in,
  input  logic             freeze,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] st_val,
  output logic [3:0]       dest,
  output logic             wb_en,
  output logic             mem_r,
  output logic             mem_w,
  output logic             out_valid,
  output logic [3:0]       status
);

  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_nzcv_next;
  logic             w_status_we;

  logic [WIDTH-1:0] r_alu_res;
  logic [WIDTH-1:0] r_st_val;
  logic [3:0]       r_dest;
  logic             r_wb_en;
  logic             r_mem_r;
  logic             r_mem_w;
  logic             r_out_valid;
  logic [3:0]       r_status;

  alu_core u_alu_core (
    .val1      (val1),
    .val2      (val2),
    .cmd       (exe_cmd),
    .c_in      (r_status[FLAG_C]),
    .v_in      (r_status[FLAG_V]),
    .result    (w_result),
    .nzcv_next (w_nzcv_next)
  );

  assign w_status_we = in_valid & s_bit & ~freeze & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else if (w_status_we) begin
      r_status <= w_nzcv_next;
    end
  end

  // Flush outranks freeze so a squashed instruction never lingers in a held stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_res   <= '0;
      r_st_val    <= '0;
      r_dest      <= '0;
      r_wb_en     <= 1'b0;
      r_mem_r     <= 1'b0;
      r_mem_w     <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_alu_res   <= '0;
      r_st_val    <= '0;
      r_dest      <= '0;
      r_wb_en     <= 1'b0;
      r_mem_r     <= 1'b0;
      r_mem_w     <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (!freeze) begin
      r_alu_res   <= w_result;
      r_st_val    <= val_rm;
      r_dest      <= dest_in;
      r_wb_en     <= wb_en_in & in_valid;
      r_mem_r     <= mem_r_in & in_valid;
      r_mem_w     <= mem_w_in & in_valid;
      r_out_valid <= in_valid;
    end
  end

  assign alu_res   = r_alu_res;
  assign st_val    = r_st_val;
  assign dest      = r_dest;
  assign wb_en     = r_wb_en;
  assign mem_r     = r_mem_r;
  assign mem_w     = r_mem_w;
  assign out_valid = r_out_valid;
  assign status    = r_status;

endmodule

// File: tb/tb_exe_alu_stage.sv
// Directed plus randomized check of exe_alu_stage against an arithmetic reference model.
module tb_exe_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] val1, val2, val_rm;
  logic [3:0]  exe_cmd;
  logic        s_bit, wb_en_in, mem_r_in, mem_w_in;
  logic [3:0]  dest_in;
  logic        freeze, flush;
  logic [31:0] alu_res, st_val;
  logic [3:0]  dest;
  logic        wb_en, mem_r, mem_w, out_valid;
  logic [3:0]  status;

  int n_assert = 0;
  int n_fail   = 0;

  // reference state
  logic [31:0] m_res, m_st;
  logic [3:0]  m_dest, m_status;
  logic        m_wb, m_mr, m_mw, m_ov;

  exe_alu_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .val1(val1), .val2(val2),
    .val_rm(val_rm), .exe_cmd(exe_cmd), .s_bit(s_bit), .wb_en_in(wb_en_in),
    .mem_r_in(mem_r_in), .mem_w_in(mem_w_in), .dest_in(dest_in), .freeze(freeze),
    .flush(flush), .alu_res(alu_res), .st_val(st_val), .dest(dest), .wb_en(wb_en),
    .mem_r(mem_r), .mem_w(mem_w), .out_valid(out_valid), .status(status)
  );

  always #5 clk = ~clk;

  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] st, output logic [31:0] r, output logic [3:0] f);
    logic c, v;
    longint unsigned ua, ub, cin, u;
    longint sa, sb, s;
    c  = st[1];
    v  = st[0];
    ua = longint'(a);
    ub = longint'(b);
    sa = $signed(a);
    sb = $signed(b);
    r  = 32'd0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd2, 4'd3: begin
        cin = (cmd == 4'd3) ? longint'(c) : 0;
        u = ua + ub + cin;
        r = u[31:0];
        c = (u > 64'hFFFF_FFFF);
        s = sa + sb + longint'(cin);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        cin = (cmd == 4'd5 && !c) ? 1 : 0;  // borrow in
        r = a - b - cin[31:0];
        c = (ua >= ub + cin);
        s = sa - sb - longint'(cin);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      default: r = 32'd0;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".alu_res"}, alu_res, m_res);
    chk({tag, ".st_val"}, st_val, m_st);
    chk({tag, ".dest"}, {28'd0, dest}, {28'd0, m_dest});
    chk({tag, ".ctrl"}, {28'd0, out_valid, wb_en, mem_r, mem_w}, {28'd0, m_ov, m_wb, m_mr, m_mw});
    chk({tag, ".status"}, {28'd0, status}, {28'd0, m_status});
    $display("%s cmd=%b v1=%h v2=%h vld=%b s=%b frz=%b fl=%b -> res=%h st=%b ov=%b wb=%b",
             tag, exe_cmd, val1, val2, in_valid, s_bit, freeze, flush, alu_res, status, out_valid, wb_en);
  endtask

  task automatic drive(input logic v, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic wb, input logic frz, input logic fl);
    in_valid = v; exe_cmd = cmd; val1 = a; val2 = b; s_bit = s; wb_en_in = wb;
    freeze = frz; flush = fl;
    val_rm = $urandom; dest_in = 4'($urandom); mem_r_in = 1'($urandom); mem_w_in = 1'($urandom);
  endtask

  // advance one edge and update the model from the inputs present before it
  task automatic step(input string tag);
    logic [31:0] r;
    logic [3:0]  f;
    ref_alu(exe_cmd, val1, val2, m_status, r, f);
    @(posedge clk);
    #1;
    if (flush) begin
      {m_res, m_st, m_dest, m_ov, m_wb, m_mr, m_mw} = '0;
    end else if (!freeze) begin
      m_res = r; m_st = val_rm; m_dest = dest_in; m_ov = in_valid;
      m_wb = wb_en_in & in_valid; m_mr = mem_r_in & in_valid; m_mw = mem_w_in & in_valid;
    end
    if (in_valid && s_bit && !freeze && !flush) m_status = f;
    chk_all(tag);
  endtask

  task automatic model_reset();
    {m_res, m_st, m_dest, m_status, m_ov, m_wb, m_mr, m_mw} = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #23;
    chk_all("reset");
    rst_n = 1'b1;  // released mid-cycle; next edge loads normally

    drive(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, 0);
    step("add_carry");
    chk("add_carry.const_res", alu_res, 32'd0);
    chk("add_carry.const_st", {28'd0, status}, 32'b0110);
    drive(1, 4'b0011, 32'd2, 32'd3, 0, 1, 0, 0);
    step("adc");
    chk("adc.const_res", alu_res, 32'd6);
    drive(1, 4'b0100, 32'd3, 32'd5, 1, 1, 0, 0);
    step("sub_neg");
    chk("sub_neg.const_st", {28'd0, status}, 32'b1000);
    drive(1, 4'b0100, 32'd5, 32'd5, 1, 0, 0, 0);
    step("cmp_eq");
    chk("cmp_eq.const_st", {28'd0, status}, 32'b0110);
    drive(1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 1, 1, 0, 0);
    step("add_ovf");
    chk("add_ovf.const_st", {28'd0, status}, 32'b1001);
    drive(1, 4'b0110, 32'hF0, 32'h0F, 1, 1, 0, 0);
    step("and_z");
    chk("and_z.const_st", {28'd0, status}, 32'b0101);
    drive(1, 4'b0101, 32'd10, 32'd3, 1, 1, 0, 0);
    step("sbc");

    for (int i = 0; i < 3; i++) begin
      drive(1, 4'($urandom_range(1, 9)), $urandom, $urandom, 1, 1, 1, 0);
      step("freeze");
    end
    drive(1, 4'b0010, 32'd1, 32'd1, 1, 1, 1, 1);
    step("flush_freeze");
    drive(0, 4'b0010, 32'd0, 32'd0, 1, 1, 0, 0);
    step("bubble");

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), 4'($urandom), $urandom, $urandom, 1'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      step("rand");
    end

    drive(1, 4'b0001, 32'hA5A5_0001, 32'hDEAD_BEEF, 1, 1, 0, 0);
    step("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset");
    #3;
    rst_n = 1'b1;
    drive(1, 4'b0010, 32'd40, 32'd2, 1, 1, 0, 0);
    step("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exe_alu_stage.md
# exe_alu_stage

Execute-stage unit of the five-stage ARM pipeline. It consumes Val1 (Rn) and the shifted or immediate Val2 produced by the operand-2 generator in the same stage. It executes the ALU command, owns the architectural NZCV status register, and registers results into the EXE/MEM pipeline boundary. Freeze and flush controls come from the hazard and branch logic.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a real instruction is present this cycle.
- `val1`  in  32  Rn value.
- `val2`  in  32  operand 2 from the operand-2 generator.
- `val_rm`  in  32  store data (Rd value for STR).
- `exe_cmd`  in  4  ALU command.
- `s_bit`  in  1  update status on this instruction.
- `wb_en_in`, `mem_r_in`, `mem_w_in`  in  1 each  control bits passed through.
- `dest_in`  in  4  destination register number.
- `freeze`  in  1  hold the stage.
- `flush`  in  1  insert a bubble.
- `alu_res`  out  32  registered ALU result or memory address.
- `st_val`  out  32  registered store data.
- `dest`  out  4  registered destination.
- `wb_en`, `mem_r`, `mem_w`, `out_valid`  out  1 each  registered control bits.
- `status`  out  4  NZCV as {N,Z,C,V}; this is the live register.

## Operation
ALU commands (exe_cmd):
- MOV 0001: result = val2
- MVN 1001: result = ~val2
- ADD 0010: result = val1+val2 (also used for LDR/STR address)
- ADC 0011: result = val1+val2+C
- SUB 0100: result = val1-val2 (also CMP)
- SBC 0101: result = val1-val2-(~C)
- AND 0110: result = val1&val2 (also TST)
- ORR 0111: result = val1|val2
- EOR 1000: result = val1^val2
- Any other code: result = 0, flags N/Z computed from 0, C/V unchanged.

Arithmetic rules:
- Add/sub computed at 33 bits.
- Add-type: C = bit 32.
- Sub-type: C = NOT borrow, so 5-3 gives C=1 and 3-5 gives C=0.
- Add-type V = (a31==b31) & (r31!=a31).
- Sub-type V = (a31!=b31) & (r31!=a31).
- N = r31; Z = (r==0) for every command.
- Logical, MOV and MVN leave C and V unchanged.
- ADC and SBC use the C currently held in `status`.

Status register:
- Written at the clock edge only when in_valid & s_bit & ~freeze & ~flush.
- Otherwise it holds its value.

Pipeline register update priority:
1. Flush. `out_valid`, `wb_en`, `mem_r` and `mem_w` go to 0. `alu_res`, `st_val` and `dest` are don't-care but must be driven to 0. Status is unchanged.
2. Freeze. All outputs and status hold.
3. Otherwise, load the new result and pass-through fields. Control bits are ANDed with in_valid.

Reset:
- All outputs and status are cleared to 0 immediately, regardless of clk.

## Timing
- Latency is one cycle: inputs sampled at edge k appear on the outputs after edge k.
- `status` changes at the same edge as `alu_res`. A dependent ADC/SBC in the next cycle therefore sees the updated C with no bypass needed.
- flush and freeze asserted together: flush wins, and status is not written.
- Reset deasserted mid-stream: the first edge after deassertion loads normally.
- Back-to-back S instructions each update status in consecutive cycles.
- The ALU is combinational and must close timing within one cycle together with the upstream operand-2 logic.

## Structure
- Package `exe_pkg` holds:
  - the exe_cmd encodings as localparams;
  - the NZCV bit-index constants N=3, Z=2, C=1, V=0.
- Sub-module `alu_core`: purely combinational. Inputs are val1, val2, cmd and c_in. Outputs are result[31:0] and nzcv_next[3:0].
- The top level holds the status register and the EXE/MEM register.

## Test plan
- Reset: drive rst_n low mid-cycle with outputs non-zero → all outputs and status go to 0 immediately.
- Carry: ADD with s_bit, 0xFFFFFFFF+1 → alu_res 0, status 0110 (Z,C). Next cycle ADC 2+3 → alu_res 6.
- Subtract: SUB with s_bit, 3-5 → 0xFFFFFFFE, status 1000. Then CMP (cmd 0100, wb_en_in 0) 5-5 → status 0110, wb_en 0.
- Overflow: ADD 0x7FFFFFFF+1 with s_bit → result 0x80000000, status 1001. AND with s_bit 0xF0&0x0F → Z set, C and V kept from before.
- Freeze and flush: freeze for 3 cycles while inputs change → outputs and status held. flush with freeze both high, carrying an S instruction → out_valid 0, wb_en 0, status unchanged.
- Bubble: in_valid 0 with wb_en_in 1 and s_bit 1 → wb_en 0, out_valid 0, status unchanged.
